// File: rtl/shift_arithmetic.sv
// Registered 32-bit arithmetic right shifter: log barrel shifter on shamt[4:0] with sign fill,
// saturating to all-sign-bits when any of shamt[31:5] is set. One cycle latency.
module shift_arithmetic (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] inp,
  input  logic [31:0] shamt,
  output logic [31:0] out,
  output logic        out_valid
);

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic         sign;
  logic         sat;
  logic [W-1:0] s16, s8, s4, s2, s1;
  logic [W-1:0] out_d, out_q;
  logic         out_valid_d, out_valid_q;

  // Barrel stages, then saturation when the shift amount reaches the full width
  always_comb begin
    sign        = inp[W-1];
    s16         = shamt[4] ? {{16{sign}}, inp[W-1:16]} : inp;
    s8          = shamt[3] ? {{8{sign}},  s16[W-1:8]}  : s16;
    s4          = shamt[2] ? {{4{sign}},  s8[W-1:4]}   : s8;
    s2          = shamt[1] ? {{2{sign}},  s4[W-1:2]}   : s4;
    s1          = shamt[0] ? {sign,       s2[W-1:1]}   : s2;
    sat         = |shamt[W-1:SW];
    out_valid_d = in_valid;
    out_d       = out_q;
    if (in_valid) begin
      out_d = sat ? {W{sign}} : s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_arithmetic.sv
// Directed self-checking bench for shift_arithmetic with a bit-serial reference for the sweep.
module tb_shift_arithmetic;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] inp;
  logic [31:0] shamt;
  logic [31:0] out;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  shift_arithmetic dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp       (inp),
    .shamt     (shamt),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drive one valid op at the falling edge, sample just after the next rising edge
  task automatic op(input logic [31:0] a, input logic [31:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    inp      = a;
    shamt    = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_sra(input logic [31:0] a, input logic [31:0] s);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < 40; i++) begin
      if (32'(i) < s) r = {r[31], r[31:1]};
    end
    return r;
  endfunction

  logic [31:0] exp_q [4];
  logic [31:0] a_q   [4];
  logic [31:0] s_q   [4];
  logic [31:0] held;
  logic [31:0] rnd;

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    inp      = '0;
    shamt    = '0;
    #12;
    chk("reset_out", out, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    op(32'h0F0F0F0F, 32'd20); chk("pos_20", out, 32'h000000F0);
    chk("pos_20_valid", 32'(out_valid), 32'h1);
    op(32'h0F0F0F0F, 32'd0);  chk("pos_0", out, 32'h0F0F0F0F);
    op(32'h0F0F0F0F, 32'd31); chk("pos_31", out, 32'h00000000);
    op(32'hF0F0F0F0, 32'd14); chk("neg_14", out, 32'hFFFFC3C3);
    op(32'hF0F0F0F0, 32'd31); chk("neg_31", out, 32'hFFFFFFFF);
    op(32'hF0F0F0F0, 32'd1);  chk("neg_1", out, 32'hF8787878);
    op(32'h0F0F0F0F, 32'd56); chk("sat_pos_56", out, 32'h00000000);
    op(32'hF0F0F0F0, 32'd35); chk("sat_neg_35", out, 32'hFFFFFFFF);
    op(32'h80000000, 32'h80000000); chk("sat_hi_only", out, 32'hFFFFFFFF);
    op(32'h7FFFFFFF, 32'd32); chk("sat_pos_32", out, 32'h00000000);

    // Back-to-back with in_valid held high
    a_q[0] = 32'h0F0F0F0F; s_q[0] = 32'd56; exp_q[0] = 32'h00000000;
    a_q[1] = 32'h0F0F0F0F; s_q[1] = 32'd20; exp_q[1] = 32'h000000F0;
    a_q[2] = 32'hF0F0F0F0; s_q[2] = 32'd14; exp_q[2] = 32'hFFFFC3C3;
    a_q[3] = 32'hF0F0F0F0; s_q[3] = 32'd35; exp_q[3] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      op(a_q[i], s_q[i]);
      chk($sformatf("b2b_%0d", i), out, exp_q[i]);
      chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'h1);
    end

    // Hold: in_valid low keeps the result and clears the valid flag
    held = out;
    @(negedge clk);
    in_valid = 1'b0;
    inp      = 32'h12345678;
    shamt    = 32'd4;
    @(posedge clk); #1;
    chk("hold_out", out, held);
    chk("hold_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    chk("hold_out_2", out, held);

    // Asynchronous reset mid-stream, away from any clock edge
    op(32'hF0F0F0F0, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out", out, 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_held_out", out, 32'h0);
    chk("rst_held_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_release_out", out, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    op(32'h0F0F0F0F, 32'd20);
    chk("post_rst_first", out, 32'h000000F0);
    chk("post_rst_first_valid", 32'(out_valid), 32'h1);

    // Sweep shift amounts 0..40 against the reference for random operands
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s <= 40; s++) begin
        rnd = $urandom;
        if (k == 1) rnd[31] = 1'b1;
        op(rnd, 32'(s));
        chk($sformatf("sweep_%08h_%0d", rnd, s), out, ref_sra(rnd, 32'(s)));
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
